// File: rtl/uart_pkg.sv
// Shared UART definitions for the coprocessor serial link (receiver and transmitter).
package uart_pkg;

  // 25 MHz system clock at 115200 baud.
  localparam int unsigned UART_CLKS_PER_BIT = 217;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; both stages reset to the line's idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_simple.sv
// 8N1 UART receiver with mid-bit sampling, a one-entry valid/ready holding register,
// and single-cycle framing/overrun error pulses.
module uart_rx_simple
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic rx_s;

  uart_sync2 #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  uart_rx_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             deliver_q, deliver_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             handshake;

  // Frame FSM: start validation, data sampling, stop check and break recovery.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    deliver_d   = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          // A start bit that is high again at mid-bit is a glitch.
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
          if (rx_s) begin
            deliver_d = 1'b1;
            state_d   = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign handshake = valid_q & data_ready;

  // Holding register: accept a new byte if empty or being drained this cycle, else overrun.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (deliver_q) begin
      if (!valid_q || handshake) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (handshake) begin
      valid_d = 1'b0;
    end
  end

  // State, counters, shift and holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      deliver_q   <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      deliver_q   <= deliver_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_simple.sv
// Self-checking bench for uart_rx_simple: frame-level reference model plus directed scenarios.
module tb_uart_rx_simple;
  import uart_pkg::*;

  localparam int unsigned CLKS = UART_CLKS_PER_BIT;
  localparam int unsigned HALF = (CLKS - 1) / 2;
  // Edges from driving the start edge to the holding-register update: 2 synchroniser,
  // 1 leaving idle, HALF+1 to the mid-start sample, 9 bit times to mid-stop, 1 to deliver.
  localparam int unsigned LAT = 2 + 1 + (HALF + 1) + 9 * CLKS + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun, busy;

  uart_rx_simple dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame outcomes scheduled by the sender: the edge at which the outcome becomes visible.
  typedef struct {
    int unsigned at;
    logic [7:0]  b;
    bit          good;
  } ev_t;
  ev_t evq[$];

  // Reference state: what the outputs must be after the latest edge.
  logic [7:0] m_data = 8'h00;
  logic       m_valid = 1'b0;
  logic       m_ferr = 1'b0;
  logic       m_ovr = 1'b0;

  int unsigned rise_cyc = 0;
  logic [7:0]  rise_data = 8'h00;
  int          rise_cnt = 0;
  int          ferr_cnt = 0;
  int          ovr_cnt = 0;
  logic        prev_valid = 1'b0;

  // Per-cycle compare against the model, then advance the model to the next edge.
  always @(negedge clk) begin
    bit   hs, del, n_ferr, n_ovr;
    ev_t  e;
    if (cyc >= 1) begin
      chk("data_valid", {31'd0, data_valid}, {31'd0, m_valid});
      chk("data_out", {24'd0, data_out}, {24'd0, m_data});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_ferr});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      if (data_valid === 1'b1 && prev_valid !== 1'b1) begin
        rise_cyc  = cyc;
        rise_data = data_out;
        rise_cnt++;
      end
      prev_valid = data_valid;
      if (frame_err === 1'b1) ferr_cnt++;
      if (overrun === 1'b1) ovr_cnt++;
    end
    n_ferr = 1'b0;
    n_ovr  = 1'b0;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      evq.delete();
    end else begin
      hs  = m_valid && (data_ready === 1'b1);
      del = 1'b0;
      if (evq.size() > 0 && evq[0].at == cyc + 1) begin
        e = evq.pop_front();
        if (e.good) begin
          if (!m_valid || hs) begin
            m_data  = e.b;
            m_valid = 1'b1;
            del     = 1'b1;
          end else begin
            n_ovr = 1'b1;
          end
        end else begin
          n_ferr = 1'b1;
        end
      end
      if (hs && !del) m_valid = 1'b0;
    end
    m_ferr = n_ferr;
    m_ovr  = n_ovr;
  end

  bit          abort = 1'b0;
  int unsigned last_s = 0;

  task automatic wait_until(input int unsigned n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame; the stop bit may be forced low and followed by extra low cycles.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input int unsigned extra_low);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    @(posedge clk);
    #1;
    last_s = cyc;
    if (stop_bit) evq.push_back('{at: cyc + LAT, b: b, good: 1'b1});
    else evq.push_back('{at: cyc + LAT - 1, b: b, good: 1'b0});
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < int'(CLKS); k++) begin
        if (abort) begin
          rx = 1'b1;
          return;
        end
        rx = fr[i];
        @(posedge clk);
        #1;
      end
    end
    for (int k = 0; k < int'(extra_low); k++) begin
      rx = 1'b0;
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned s;
    int          f0, o0, r0;

    // Reset state.
    idle(4);
    chk("reset data_valid", {31'd0, data_valid}, 32'd0);
    chk("reset data_out", {24'd0, data_out}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset frame_err", {31'd0, frame_err}, 32'd0);
    rst = 1'b0;
    idle(10);

    // 1: single byte, consumer always ready.
    data_ready = 1'b1;
    r0 = rise_cnt;
    send_frame(8'h46, 1'b1, 0);
    s = last_s;
    chk("t1 latency", rise_cyc - s, 32'd2066);
    chk("t1 byte", {24'd0, rise_data}, 32'h46);
    chk("t1 one delivery", rise_cnt - r0, 32'd1);
    idle(5);
    chk("t1 busy idle", {31'd0, busy}, 32'd0);

    // 2: short low glitch on the line.
    idle(20);
    r0 = rise_cnt;
    f0 = ferr_cnt;
    @(posedge clk);
    #1;
    s  = cyc;
    rx = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rx = 1'b1;
    wait_until(s + 3 + HALF);
    chk("t2 busy before sample", {31'd0, busy}, 32'd1);
    wait_until(s + 4 + HALF);
    chk("t2 busy after sample", {31'd0, busy}, 32'd0);
    idle(20);
    chk("t2 no delivery", rise_cnt - r0, 32'd0);
    chk("t2 no frame_err", ferr_cnt - f0, 32'd0);

    // 3: bad stop bit followed by a held-low break.
    f0 = ferr_cnt;
    r0 = rise_cnt;
    send_frame(8'h55, 1'b0, 3 * CLKS);
    s = cyc;
    chk("t3 one frame_err", ferr_cnt - f0, 32'd1);
    wait_until(s + 2);
    chk("t3 busy in break", {31'd0, busy}, 32'd1);
    wait_until(s + 3);
    chk("t3 busy released", {31'd0, busy}, 32'd0);
    idle(20);
    chk("t3 no delivery", rise_cnt - r0, 32'd0);

    // 4: consumer stalled, second byte overruns.
    data_ready = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, 0);
    send_frame(8'h3C, 1'b1, 0);
    idle(5);
    chk("t4 data held", {24'd0, data_out}, 32'hA5);
    chk("t4 valid held", {31'd0, data_valid}, 32'd1);
    chk("t4 one overrun", ovr_cnt - o0, 32'd1);
    data_ready = 1'b1;
    idle(2);
    data_ready = 1'b0;
    chk("t4 drained", {31'd0, data_valid}, 32'd0);

    // 5: ready raised exactly on the cycle a new byte is delivered.
    idle(10);
    send_frame(8'h11, 1'b1, 0);
    idle(3);
    chk("t5 holding 11", {24'd0, data_out}, 32'h11);
    o0 = ovr_cnt;
    fork
      send_frame(8'h22, 1'b1, 0);
      begin
        @(posedge clk);
        #2;
        wait_until(last_s + LAT - 1);
        data_ready = 1'b1;
        @(posedge clk);
        #1;
        data_ready = 1'b0;
        chk("t5 valid stays", {31'd0, data_valid}, 32'd1);
        chk("t5 data 22", {24'd0, data_out}, 32'h22);
      end
    join
    idle(3);
    chk("t5 no overrun", ovr_cnt - o0, 32'd0);

    // 6: reset in the middle of data bit 4, with 0x22 still held.
    fork
      send_frame(8'hC3, 1'b1, 0);
      begin
        @(posedge clk);
        #2;
        wait_until(last_s + 4 + HALF + 4 * CLKS + CLKS / 2);
        abort = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        chk("t6 rst data_valid", {31'd0, data_valid}, 32'd0);
        chk("t6 rst data_out", {24'd0, data_out}, 32'd0);
        chk("t6 rst busy", {31'd0, busy}, 32'd0);
        chk("t6 rst flags", {30'd0, frame_err, overrun}, 32'd0);
        idle(3);
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    idle(CLKS);
    data_ready = 1'b1;
    r0 = rise_cnt;
    send_frame(8'h7E, 1'b1, 0);
    chk("t6 byte 7E", {24'd0, rise_data}, 32'h7E);
    chk("t6 one delivery", rise_cnt - r0, 32'd1);
    idle(5);
    chk("t6 consumed", {31'd0, data_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound on run length.
  initial begin
    #(60000 * 10);
    failures++;
    $display("FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
